simon_input_capture: RTL

Front-end for the Simon player controls: synchronizes and debounces the raw "submit" push-button, samples the pattern switches at the debounced press, and emits a one-cycle `valid` strobe with a stable `pattern_out` on the debounced release. It is the producer of the `valid`/pattern interface that the Simon control FSM and pattern datapath consume. The controller drives `arm` to say when presses are accepted.

---
 rtl/simon_pkg.sv | 14 +
 rtl/simon_debounce.sv | 49 ++++
 rtl/simon_input_capture.sv | 87 ++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon player-input front end: FSM encoding and default sizing.
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    IGNORE = 2'd2,
    FIRE   = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH           = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/simon_debounce.sv
// Submit-button synchronizer and debouncer with one-cycle rise/fall pulses on the debounced level.
module simon_debounce
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          btn_sync;
  logic          btn_stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  assign btn_sync = sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync       <= '0;
      btn_stable <= 1'b0;
      stable_q   <= 1'b0;
      cnt        <= '0;
    end else begin
      sync     <= {sync[0], btn_raw};
      stable_q <= btn_stable;
      // Any single cycle of agreement restarts the disagreement window.
      if (btn_sync == btn_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_stable <= btn_sync;
        cnt        <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = btn_stable & ~stable_q;
  assign fall = ~btn_stable & stable_q;

endmodule

// File: rtl/simon_input_capture.sv
// Simon player-input front end: debounced submit button, pattern capture and valid strobe.
// Optional macro SIMON_INPUT_REJECT_ZERO_EN suppresses valid for all-zero patterns.
module simon_input_capture
  import simon_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             arm,
  output logic             valid,
  output logic [WIDTH-1:0] pattern_out,
  output logic             busy
);

  logic [WIDTH-1:0] sw_meta;
  logic [WIDTH-1:0] sw_sync;
  logic             rise;
  logic             fall;
  state_t           state;

  simon_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pattern_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            if (arm) begin
              pattern_out <= sw_sync;
              state       <= HELD;
            end else begin
              state <= IGNORE;
            end
          end
        end
        HELD: begin
          // Withdrawn arm wins over a simultaneous release.
          if (!arm) begin
            state <= IGNORE;
          end else if (fall) begin
`ifdef SIMON_INPUT_REJECT_ZERO_EN
            state <= (pattern_out == '0) ? IDLE : FIRE;
`else
            state <= FIRE;
`endif
          end
        end
        IGNORE: begin
          if (fall) state <= IDLE;
        end
        FIRE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign valid = (state == FIRE);
  assign busy  = (state != IDLE);

endmodule
